// File: rtl/lcd_id_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_id_detect : debounced LCD panel strap reader with ID/resolution decode |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module lcd_id_detect #(
  parameter int STRAP_W    = 3,
  parameter int SETTLE_CYC = 1000,
  parameter int STABLE_CNT = 16,
  parameter int MAX_GLITCH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STRAP_W-1:0] strap_in,
  input  logic               redetect,
  output logic [15:0]        lcd_id,
  output logic [10:0]        h_res,
  output logic [10:0]        v_res,
  output logic [STRAP_W-1:0] strap_code,
  output logic               id_valid,
  output logic               id_error,
  output logic [1:0]         err_code
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int STB_W = $clog2(STABLE_CNT + 1);
  localparam int GLT_W = $clog2(MAX_GLITCH + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [STB_W-1:0] STABLE_LAST = STB_W'(STABLE_CNT - 1);
  localparam logic [GLT_W-1:0] GLITCH_LAST = GLT_W'(MAX_GLITCH - 1);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_DONE   = 2'd2,
    ST_FAIL   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [STRAP_W-1:0] sync1_q, strap_sync_q;
  logic [STRAP_W-1:0] ref_q, ref_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [STB_W-1:0]   stab_q, stab_d;
  logic [GLT_W-1:0]   glitch_q, glitch_d;
  logic [15:0]        lcd_id_q, lcd_id_d;
  logic [10:0]        h_res_q, h_res_d, v_res_q, v_res_d;
  logic [STRAP_W-1:0] code_q, code_d;
  logic               valid_q, valid_d, error_q, error_d;
  logic [1:0]         err_q, err_d;

  // Decode of the currently synchronised strap value
  logic        dec_known;
  logic [15:0] dec_id;
  logic [10:0] dec_h, dec_v;

  always_comb begin
    dec_known = 1'b1;
    dec_id    = 16'h0000;
    dec_h     = 11'd0;
    dec_v     = 11'd0;
    case (strap_sync_q[2:0])
      3'b000:  begin dec_id = 16'h4342; dec_h = 11'd480;  dec_v = 11'd272; end
      3'b001:  begin dec_id = 16'h7084; dec_h = 11'd800;  dec_v = 11'd480; end
      3'b010:  begin dec_id = 16'h7016; dec_h = 11'd1024; dec_v = 11'd600; end
      3'b100:  begin dec_id = 16'h4384; dec_h = 11'd800;  dec_v = 11'd480; end
      3'b101:  begin dec_id = 16'h1018; dec_h = 11'd1280; dec_v = 11'd800; end
      default: dec_known = 1'b0;
    endcase
    if ((strap_sync_q >> 3) != '0) begin
      dec_known = 1'b0;
    end
    if (!dec_known) begin
      dec_id = 16'h0000;
      dec_h  = 11'd0;
      dec_v  = 11'd0;
    end
  end

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    settle_d = settle_q;
    stab_d   = stab_q;
    glitch_d = glitch_q;
    lcd_id_d = lcd_id_q;
    h_res_d  = h_res_q;
    v_res_d  = v_res_q;
    code_d   = code_q;
    valid_d  = valid_q;
    error_d  = error_q;
    err_d    = err_q;
    case (state_q)
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = ST_SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      ST_SAMPLE: begin
        // stab_q == 0 only on the first SAMPLE edge
        if (stab_q == '0) begin
          ref_d    = strap_sync_q;
          stab_d   = STB_W'(1);
          glitch_d = '0;
        end else if (strap_sync_q == ref_q) begin
          if (stab_q == STABLE_LAST) begin
            state_d  = ST_DONE;
            lcd_id_d = dec_id;
            h_res_d  = dec_h;
            v_res_d  = dec_v;
            code_d   = strap_sync_q;
            valid_d  = 1'b1;
            error_d  = !dec_known;
            err_d    = dec_known ? 2'd0 : 2'd1;
          end else begin
            stab_d = stab_q + STB_W'(1);
          end
        end else begin
          ref_d  = strap_sync_q;
          stab_d = STB_W'(1);
          if (glitch_q == GLITCH_LAST) begin
            state_d  = ST_FAIL;
            lcd_id_d = 16'h0000;
            h_res_d  = 11'd0;
            v_res_d  = 11'd0;
            code_d   = strap_sync_q;
            valid_d  = 1'b1;
            error_d  = 1'b1;
            err_d    = 2'd2;
          end else begin
            glitch_d = glitch_q + GLT_W'(1);
          end
        end
      end
      default: begin
        if (redetect) begin
          state_d  = ST_SETTLE;
          ref_d    = '0;
          settle_d = '0;
          stab_d   = '0;
          glitch_d = '0;
          lcd_id_d = 16'h0000;
          h_res_d  = 11'd0;
          v_res_d  = 11'd0;
          code_d   = '0;
          valid_d  = 1'b0;
          error_d  = 1'b0;
          err_d    = 2'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      strap_sync_q <= '0;
      state_q      <= ST_SETTLE;
      ref_q        <= '0;
      settle_q     <= '0;
      stab_q       <= '0;
      glitch_q     <= '0;
      lcd_id_q     <= 16'h0000;
      h_res_q      <= 11'd0;
      v_res_q      <= 11'd0;
      code_q       <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      err_q        <= 2'd0;
    end else begin
      sync1_q      <= strap_in;
      strap_sync_q <= sync1_q;
      state_q      <= state_d;
      ref_q        <= ref_d;
      settle_q     <= settle_d;
      stab_q       <= stab_d;
      glitch_q     <= glitch_d;
      lcd_id_q     <= lcd_id_d;
      h_res_q      <= h_res_d;
      v_res_q      <= v_res_d;
      code_q       <= code_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
      err_q        <= err_d;
    end
  end

  assign lcd_id     = lcd_id_q;
  assign h_res      = h_res_q;
  assign v_res      = v_res_q;
  assign strap_code = code_q;
  assign id_valid   = valid_q;
  assign id_error   = error_q;
  assign err_code   = err_q;

endmodule
`default_nettype wire
